quantum_state_preparer: RTL and testbench

- Converts a vector of four magnitude-squared probabilities into a 2-qubit state vector of real, zero-phase complex amplitudes: amp = sqrt(mag_sq), imag = 0.
- Uses one shared restoring square-root datapath, iterated bit-serially, with a valid/ready handshake on each side.
- Sits upstream of the gate/QFT pipeline as its state-load path.
- Its input and output packings are exactly the inverse of the magnitude-squared extraction stage.

---
 rtl/quantum_state_preparer.sv | 187 ++++++++++++++++++
 tb/tb_quantum_state_preparer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/quantum_state_preparer.sv
// Loads a 2-qubit state: four magnitude-squared words become real, zero-phase amplitudes through one shared bit-serial restoring square root.
// Optional input-normalization flag is built only when STATE_PREP_NORM_CHECK_EN is defined.
`ifndef TOTAL_BITS
`define TOTAL_BITS 16
`endif
`ifndef FX_BITS
`define FX_BITS 14
`endif

module quantum_state_preparer #(
  parameter int TOTAL_BITS = `TOTAL_BITS,
  parameter int FX_BITS    = `FX_BITS,
  parameter int NORM_TOL   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TOTAL_BITS*4-1:0] mag_sq_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TOTAL_BITS*8-1:0] q_state_out,
  output logic [3:0]              neg_in,
  output logic                    norm_err
);

  localparam int RAD_W = 2 * TOTAL_BITS;
  localparam int REM_W = TOTAL_BITS + 2;
  localparam int TRY_W = TOTAL_BITS + 4;
  localparam int CNT_W = (TOTAL_BITS > 2) ? $clog2(TOTAL_BITS) : 1;

  if (FX_BITS > TOTAL_BITS - 2 || FX_BITS < 0 || NORM_TOL < 0) begin : g_param_check
    $error("quantum_state_preparer: illegal FX_BITS/NORM_TOL for TOTAL_BITS");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    NEXT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]                    idx;
  logic [CNT_W-1:0]              cnt;
  logic [TOTAL_BITS*4-1:0]       mag_cap;
  logic signed [TOTAL_BITS-1:0]  cur_mag;
  logic                          cur_neg;
  logic [RAD_W-1:0]              rad;
  logic [REM_W-1:0]              rem;
  logic [REM_W-1:0]              rem_nxt;
  logic [TOTAL_BITS-1:0]         root;
  logic [TOTAL_BITS-1:0]         root_nxt;
  logic [TRY_W-1:0]              shifted;
  logic [TRY_W-1:0]              trial;
  logic                          bit_ok;
  logic signed [TOTAL_BITS-1:0]  real_work [4];
  logic [TOTAL_BITS*8-1:0]       work_packed;
  logic                          capture;

  assign capture  = (state == IDLE) && in_valid;
  assign in_ready = (state == IDLE) && !rst;
  assign cur_mag  = mag_cap[(3 - int'(idx))*TOTAL_BITS +: TOTAL_BITS];
  assign cur_neg  = cur_mag[TOTAL_BITS-1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = LOAD;
      LOAD: state_nxt = ITER;
      ITER: if (cnt == '0) state_nxt = NEXT;
      NEXT: state_nxt = (idx == 2'd3) ? DONE : LOAD;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring step: shift in two radicand bits, try subtracting (root<<2)|1
  always_comb begin
    shifted  = {rem, rad[RAD_W-1 -: 2]};
    trial    = {2'b00, root, 2'b01};
    bit_ok   = (shifted >= trial);
    rem_nxt  = bit_ok ? REM_W'(shifted - trial) : REM_W'(shifted);
    root_nxt = {root[TOTAL_BITS-2:0], bit_ok};
  end

  always_comb begin
    work_packed = '0;
    for (int i = 0; i < 4; i++) begin
      work_packed[(7 - 2*i)*TOTAL_BITS +: TOTAL_BITS] = real_work[i];
    end
  end

  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) mag_cap <= mag_sq_in;
      LOAD: begin
        rad  <= cur_neg ? '0 : (RAD_W'(cur_mag) << FX_BITS);
        root <= '0;
        rem  <= '0;
      end
      ITER: begin
        rad  <= rad << 2;
        root <= root_nxt;
        rem  <= rem_nxt;
      end
      NEXT: real_work[idx] <= root;
      default: ;
    endcase
  end

  // Results land in q_state_out only on DONE entry so the previous vector stays visible while computing
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      q_state_out <= '0;
      neg_in      <= '0;
      idx         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          idx    <= '0;
          neg_in <= '0;
        end
        LOAD: begin
          cnt <= CNT_W'(TOTAL_BITS - 1);
          if (cur_neg) neg_in[~idx] <= 1'b1;
        end
        ITER: cnt <= cnt - 1'b1;
        NEXT: if (idx != 2'd3) idx <= idx + 2'd1;
        DONE: begin
          if (!out_valid) begin
            out_valid   <= 1'b1;
            q_state_out <= work_packed;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STATE_PREP_NORM_CHECK_EN
  localparam logic signed [TOTAL_BITS+2:0] ONE_FX = (TOTAL_BITS+3)'(1) << FX_BITS;
  localparam logic signed [TOTAL_BITS+2:0] TOL    = (TOTAL_BITS+3)'(NORM_TOL);

  function automatic logic [TOTAL_BITS+1:0] clamp_ext(input logic signed [TOTAL_BITS-1:0] v);
    return v[TOTAL_BITS-1] ? '0 : {2'b00, v};
  endfunction

  logic [TOTAL_BITS+1:0]        norm_sum;
  logic signed [TOTAL_BITS+2:0] norm_diff;
  logic                         norm_bad;
  logic                         norm_pend;

  always_comb begin
    norm_sum = '0;
    for (int i = 0; i < 4; i++) begin
      norm_sum = norm_sum + clamp_ext(mag_sq_in[i*TOTAL_BITS +: TOTAL_BITS]);
    end
    norm_diff = $signed({1'b0, norm_sum}) - ONE_FX;
    norm_bad  = (norm_diff > TOL) || (norm_diff < -TOL);
  end

  always_ff @(posedge clk) begin
    if (capture) norm_pend <= norm_bad;
  end

  always_ff @(posedge clk) begin
    if (rst)                            norm_err <= 1'b0;
    else if (capture)                   norm_err <= 1'b0;
    else if (state == DONE && !out_valid) norm_err <= norm_pend;
  end
`else
  assign norm_err = 1'b0;
`endif

endmodule

// File: tb/tb_quantum_state_preparer.sv
// Directed bench for quantum_state_preparer at TOTAL_BITS=16, FX_BITS=14 (1.0 = 16384).
module tb_quantum_state_preparer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  mag_sq_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] q_state_out;
  logic [3:0]   neg_in;
  logic         norm_err;

  int checks = 0;
  int errors = 0;

`ifdef STATE_PREP_NORM_CHECK_EN
  localparam logic NORM_MAX = 1'b1;
`else
  localparam logic NORM_MAX = 1'b0;
`endif

  always #5 clk = ~clk;

  quantum_state_preparer #(
    .TOTAL_BITS(16),
    .FX_BITS(14),
    .NORM_TOL(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mag_sq_in(mag_sq_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q_state_out(q_state_out),
    .neg_in(neg_in),
    .norm_err(norm_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] amps(input logic [15:0] e0, input logic [15:0] e1,
                                        input logic [15:0] e2, input logic [15:0] e3);
    return {e0, 16'h0, e1, 16'h0, e2, 16'h0, e3, 16'h0};
  endfunction

  // Called at a negedge with the block idle; returns at the first negedge with out_valid high
  task automatic run_vector(input string tag, input logic [63:0] v, input logic [127:0] prev_q);
    int lat;
    mag_sq_in = v;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    check({tag, "_neg_clr"}, neg_in, 4'b0);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 40) check({tag, "_hold_prev"}, q_state_out, prev_q);
    end
    check({tag, "_latency"}, lat, 73);
  endtask

  task automatic finish_xfer(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_vld_drop"}, out_valid, 1'b0);
    check({tag, "_rdy_rise"}, in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mag_sq_in = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_q", q_state_out, 128'h0);
    check("rst_neg", neg_in, 4'b0);
    check("rst_norm", norm_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1'b1);

    run_vector("uniform", {4{16'd4096}}, 128'h0);
    check("uniform_q", q_state_out, amps(16'd8192, 16'd8192, 16'd8192, 16'd8192));
    check("uniform_neg", neg_in, 4'b0);
    check("uniform_norm", norm_err, 1'b0);
    finish_xfer("uniform");

    run_vector("basis00", {16'd16384, 48'd0}, amps(16'd8192, 16'd8192, 16'd8192, 16'd8192));
    check("basis00_q", q_state_out, amps(16'd16384, 16'd0, 16'd0, 16'd0));
    check("basis00_neg", neg_in, 4'b0);
    check("basis00_norm", norm_err, 1'b0);
    finish_xfer("basis00");

    run_vector("negin", {16'hFF9C, 16'd16384, 32'd0}, amps(16'd16384, 16'd0, 16'd0, 16'd0));
    check("negin_q", q_state_out, amps(16'd0, 16'd16384, 16'd0, 16'd0));
    check("negin_neg", neg_in, 4'b1000);
    check("negin_norm", norm_err, 1'b0);
    finish_xfer("negin");

    run_vector("maxin", {4{16'h7FFF}}, amps(16'd0, 16'd16384, 16'd0, 16'd0));
    check("maxin_q", q_state_out, amps(16'd23170, 16'd23170, 16'd23170, 16'd23170));
    check("maxin_neg", neg_in, 4'b0);
    check("maxin_norm", norm_err, NORM_MAX);

    // Stall downstream; a stray in_valid during DONE must be dropped
    repeat (10) @(negedge clk);
    check("stall_ready", in_ready, 1'b0);
    mag_sq_in = {4{16'd4096}};
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("stall_valid", out_valid, 1'b1);
    check("stall_ready2", in_ready, 1'b0);
    check("stall_q", q_state_out, amps(16'd23170, 16'd23170, 16'd23170, 16'd23170));
    check("stall_norm", norm_err, NORM_MAX);
    finish_xfer("stall");
    repeat (3) @(negedge clk);
    check("no_buffer_valid", out_valid, 1'b0);
    check("no_buffer_ready", in_ready, 1'b1);

    // Reset mid-computation
    mag_sq_in = {4{16'd4096}};
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_q", q_state_out, 128'h0);
    check("midrst_neg", neg_in, 4'b0);
    check("midrst_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", in_ready, 1'b1);
    run_vector("after_rst", {4{16'd4096}}, 128'h0);
    check("after_rst_q", q_state_out, amps(16'd8192, 16'd8192, 16'd8192, 16'd8192));
    finish_xfer("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
